// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between the CPU (C) and the loader (L).
// Optional grant locking for bursts is compiled in with `define MEM_PORT_ARBITER_LOCK_EN.
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic          c_lock,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_lock,
    output logic          l_ack,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    logic [1:0]    state_reg;
    logic [3:0]    cnt_reg;
    logic          owner_reg;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic [DW-1:0] c_rdata_reg;
    logic [DW-1:0] l_rdata_reg;

    logic          grant_valid;
    logic          grant_sel;
    logic          lock_hold;

`ifdef MEM_PORT_ARBITER_LOCK_EN
    // Remembers whether the owner asked to keep the port at its last ACK;
    // only meaningful in the IDLE cycle that immediately follows ACK.
    logic lock_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_reg <= 1'b0;
        end else begin
            lock_reg <= (state_reg == ACK) && (owner_reg ? l_lock : c_lock);
        end
    end

    assign lock_hold = lock_reg && (owner_reg ? l_req : c_req);
`else
    logic unused_lock;
    assign unused_lock = c_lock ^ l_lock;
    assign lock_hold   = 1'b0;
`endif

    always_comb begin
        grant_valid = c_req | l_req;
        grant_sel   = owner_reg;
        if (lock_hold) begin
            grant_sel = owner_reg;
        end else if (c_req && l_req) begin
            grant_sel = ~owner_reg;
        end else begin
            grant_sel = l_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            owner_reg     <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            c_rdata_reg   <= '0;
            l_rdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        owner_reg     <= grant_sel;
                        mem_we_reg    <= grant_sel ? l_we    : c_we;
                        mem_addr_reg  <= grant_sel ? l_addr  : c_addr;
                        mem_wdata_reg <= grant_sel ? l_wdata : c_wdata;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_we_reg) begin
                        state_reg <= ACK;
                    end else begin
                        cnt_reg   <= LAT_INIT;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        if (owner_reg) begin
                            l_rdata_reg <= mem_rdata;
                        end else begin
                            c_rdata_reg <= mem_rdata;
                        end
                        state_reg <= ACK;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state_reg == ISSUE);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign c_ack     = (state_reg == ACK) && !owner_reg;
    assign l_ack     = (state_reg == ACK) &&  owner_reg;
    assign c_rdata   = c_rdata_reg;
    assign l_rdata   = l_rdata_reg;
    assign owner     = owner_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide memory port between the multicycle CPU controller/datapath (requester C) and the program loader (requester L).
- Round-robin arbitration with a req/ack handshake; one single-beat transaction at a time.
- Latches the winner's address and data, sequences the memory timing for a fixed read latency, and returns read data with ack.
- Sits between both masters and the memory macro.

Parameters:
AW, 8, address width
DW, 8, data width
MEM_LAT, 1, cycles from mem_en (read) to valid mem_rdata; legal 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
c_req  in  1  CPU request; held until c_ack
c_we  in  1  CPU write (1) / read (0)
c_addr  in  AW  CPU address
c_wdata  in  DW  CPU write data
c_lock  in  1  CPU keeps grant for next transaction (see Optional Feature)
c_ack  out  1  one-cycle completion pulse to CPU
c_rdata  out  DW  read data, valid while c_ack=1
l_req, l_we, l_addr, l_wdata, l_lock  in  1/1/AW/DW/1  loader equivalents
l_ack  out  1  one-cycle completion pulse to loader
l_rdata  out  DW  read data, valid while l_ack=1
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
owner  out  1  current/last grant: 0=C, 1=L
busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, ACK.
- Reset: state IDLE; outputs c_ack, l_ack, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, c_rdata, l_rdata = 0; owner=1, so C wins the first tie.
- Reset mid-operation: transaction abandoned with no ack; mem_en=0 from the cycle after the reset edge.
- IDLE, no req: stay in IDLE.
- IDLE, one req: grant it.
- IDLE, both req: grant the requester != owner.
- On grant: latch we/addr/wdata into mem_we/mem_addr/mem_wdata; update owner; go to ISSUE.
- ISSUE: mem_en=1 for exactly this cycle.
  - Write: go to ACK.
  - Read: load a 4-bit counter with MEM_LAT-1; go to WAIT.
- WAIT: mem_en=0. Decrement the counter. At count 0, register mem_rdata into the owner's rdata and go to ACK.
- ACK: owner's ack=1 for one cycle, then IDLE. Non-owner ack stays 0.
- Latency, req sampled in IDLE at cycle 0:
  - ISSUE at cycle 1.
  - Write ack at cycle 2.
  - Read ack at cycle 2+MEM_LAT.
- rdata holds its value until the next read for that requester.
- Requester inputs are ignored outside IDLE; changing addr/wdata mid-transaction has no effect.
- A req dropped before its ack still completes and still acks.
- A req still high in the IDLE after ACK is a new transaction; a registered master must clear req on seeing ack.
- Back-to-back, both requesting continuously: grants alternate C,L,C,L.
- Idle gap between transactions: none beyond the mandatory IDLE cycle.
- Every transaction occupies at least 3 cycles (IDLE, ISSUE, ACK).

Optional Feature:
- Macro: MEM_PORT_ARBITER_LOCK_EN.
- Defined:
  - If the owner's lock=1 during ACK, the next IDLE grants the owner only when its req=1, regardless of the other req.
  - If the owner's req=0 in that IDLE, normal arbitration applies.
  - owner is unchanged on a locked regrant.
  - The lock persists as long as lock stays high at each ACK; this lets CPU FETCH1-4 run as an uninterrupted 4-byte burst.
- Undefined: c_lock/l_lock are ignored (ports remain); pure round-robin.

Test Plan:
1. MEM_LAT=2, reset, then CPU read addr 0x10 with mem returning 0xA5 at ISSUE+2 -> mem_en high cycle 1 only, c_ack at cycle 4, c_rdata=0xA5, l_ack=0.
2. Loader write addr 0x20 data 0x3C -> mem_en=mem_we=1 with addr 0x20/data 0x3C in cycle 1, l_ack at cycle 2, c_rdata unchanged.
3. First transaction after reset, c_req and l_req both high from cycle 0 -> C granted first, then L, then C; owner toggles 0,1,0.
4. Reset asserted during WAIT of a read -> no ack ever, mem_en=0 after the reset edge, busy=0, owner=1.
5. c_req dropped one cycle after grant (write) -> transaction completes; c_ack pulses once; arbiter returns to IDLE.
6. LOCK_EN defined, CPU with c_lock=1 issuing reads 0x00-0x03 while l_req held high -> four consecutive C grants, then L granted once c_lock=0 at ACK; without macro -> grants alternate C,L,C,L.
